// File: rtl/param_seq_multiplier_if.sv
// Start/busy/done bundle between the issue logic (master) and the sequential multiplier (slave).
// The issue logic raises start with the operands. The multiplier accepts it only while busy is low.
// done then pulses for one cycle when result becomes valid.
interface param_seq_multiplier_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic                 is_signed;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic [2*WIDTH-1:0]   result;
  logic                 busy;
  logic                 done;

  modport master (
    output start, is_signed, A, B,
    input  result, busy, done
  );

  modport slave (
    input  start, is_signed, A, B,
    output result, busy, done
  );
endinterface

// File: rtl/param_seq_multiplier.sv
// Iterative shift-add multiplier: sign/magnitude split, one multiplier bit per cycle, full 2*WIDTH product.
// Optional EARLY_TERM_EN: leave CALC as soon as the remaining multiplier bits are all zero.
module param_seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  param_seq_multiplier_if.slave bus,
  output logic                 o_dbg_state
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PW-1:0]    r_mag_a;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_result;
  logic [WIDTH-1:0] r_mag_b;
  logic [CW-1:0]    r_cnt;
  logic             r_neg;
  logic             r_done;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH-1:0] w_mag_b_shr;
  logic [PW-1:0]    w_acc_add;
  logic [PW-1:0]    w_prod;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    // A WIDTH-bit unsigned magnitude holds |-2^(W-1)| exactly.
    w_abs_a     = (bus.is_signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    w_abs_b     = (bus.is_signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;
    w_mag_b_shr = r_mag_b >> 1;
    w_acc_add   = r_mag_b[0] ? (r_acc + r_mag_a) : r_acc;
    w_prod      = r_neg ? -w_acc_add : w_acc_add;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = CALC;
        end
      end
      CALC: begin
`ifdef EARLY_TERM_EN
        w_last = (r_cnt == LAST_CNT) || (w_mag_b_shr == '0);
`else
        w_last = (r_cnt == LAST_CNT);
`endif
        if (w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_mag_a  <= '0;
      r_mag_b  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      if (w_accept) begin
        r_mag_a <= {{WIDTH{1'b0}}, w_abs_a};
        r_mag_b <= w_abs_b;
        r_neg   <= bus.is_signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
        r_acc   <= '0;
        r_cnt   <= '0;
      end else if (r_state == CALC) begin
        r_acc   <= w_acc_add;
        r_mag_a <= r_mag_a << 1;
        r_mag_b <= w_mag_b_shr;
        r_cnt   <= r_cnt + 1'b1;
        if (w_last) begin
          r_result <= w_prod;
          r_done   <= 1'b1;
        end
      end
    end
  end

  assign bus.busy     = (r_state == CALC);
  assign bus.done     = r_done;
  assign bus.result   = r_result;
  assign o_dbg_state  = r_state;
endmodule
